// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared lc3b pipeline types: data-memory access FSM states and counter width.
package lc3b_types_pkg;

    typedef enum logic [1:0] {
        D_ACC1 = 2'd0,
        D_ACC2 = 2'd1,
        D_DONE = 2'd2
    } dmem_state_e;

    localparam int unsigned STALL_W = 16;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Handshake bundle between the pipeline datapath (master) and the stall controller (slave).
interface pipeline_stall_ctrl_if;
    import lc3b_types_pkg::*;

    logic               imem_resp;
    logic               mem_valid;
    logic               mem_dmem_op;
    logic               mem_indirect;
    logic               dmem_resp;
    logic               load_use;
    logic               br_taken;

    logic               imem_read;
    logic               dmem_req;
    logic               dmem_phase;
    logic               load_pc;
    logic               load_if_id;
    logic               load_id_ex;
    logic               load_ex_mem;
    logic               load_mem_wb;
    logic               flush_if_id;
    logic               flush_id_ex;
    logic               flush_ex_mem;
    logic [STALL_W-1:0] stall_count;

    modport master (
        output imem_resp, mem_valid, mem_dmem_op, mem_indirect, dmem_resp, load_use, br_taken,
        input  imem_read, dmem_req, dmem_phase, load_pc, load_if_id, load_id_ex, load_ex_mem,
               load_mem_wb, flush_if_id, flush_id_ex, flush_ex_mem, stall_count
    );

    modport slave (
        input  imem_resp, mem_valid, mem_dmem_op, mem_indirect, dmem_resp, load_use, br_taken,
        output imem_read, dmem_req, dmem_phase, load_pc, load_if_id, load_id_ex, load_ex_mem,
               load_mem_wb, flush_if_id, flush_id_ex, flush_ex_mem, stall_count
    );

endinterface

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign count_d = (inc_i && (count_q != '1)) ? count_q + WIDTH'(1) : count_q;

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller: waits for fetch and (possibly two-step) data access, then advances.
module pipeline_stall_ctrl
    import lc3b_types_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    pipeline_stall_ctrl_if.slave bus
);

    dmem_state_e state_q, state_d;
    logic        imem_done_q, imem_done_d;
    logic        need_dmem;
    logic        mem_ready;
    logic        if_ready;
    logic        advance;
    logic        hold_front;

    assign need_dmem = bus.mem_valid & bus.mem_dmem_op;
    assign mem_ready = ~need_dmem
                     | (state_q == D_DONE)
                     | ((state_q == D_ACC2) & bus.dmem_resp)
                     | ((state_q == D_ACC1) & bus.dmem_resp & ~bus.mem_indirect);
    assign if_ready  = bus.imem_resp | imem_done_q;
    // Reset gates advance so every load/flush enable is quiet while rst_n is low.
    assign advance   = rst_n & if_ready & mem_ready;

    // NOTE: combinational blocks assign a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            D_ACC1:  if (bus.dmem_resp) state_d = bus.mem_indirect ? D_ACC2 : D_DONE;
            D_ACC2:  if (bus.dmem_resp) state_d = D_DONE;
            D_DONE:  state_d = D_DONE;
            default: state_d = D_ACC1;
        endcase
        if (advance) state_d = D_ACC1;
    end

    assign imem_done_d = advance ? 1'b0 : (imem_done_q | bus.imem_resp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= D_ACC1;
            imem_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            imem_done_q <= imem_done_d;
        end
    end

    // A taken branch overrides a load-use hold: the PC must move to the target.
    assign hold_front = bus.load_use & ~bus.br_taken;

    assign bus.imem_read    = rst_n & ~imem_done_q;
    assign bus.dmem_req     = rst_n & need_dmem & (state_q != D_DONE);
    assign bus.dmem_phase   = rst_n & (state_q == D_ACC2);
    assign bus.load_pc      = advance & ~hold_front;
    assign bus.load_if_id   = advance & ~hold_front;
    assign bus.load_id_ex   = advance;
    assign bus.load_ex_mem  = advance;
    assign bus.load_mem_wb  = advance;
    assign bus.flush_if_id  = advance & bus.br_taken;
    assign bus.flush_id_ex  = advance & (bus.load_use | bus.br_taken);
    assign bus.flush_ex_mem = advance & bus.br_taken;

    sat_counter #(
        .WIDTH (STALL_W)
    ) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (~advance),
        .count_o (bus.stall_count)
    );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench: transaction-level model (accesses done per instruction) plus directed cases.
module tb_pipeline_stall_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl_if bus ();

    pipeline_stall_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Model state: data accesses completed for the MEM instruction, fetch completed, stall total.
    int m_k;
    bit m_fetched;
    int m_stalls;
    bit m_adv_last;

    function automatic int m_needed();
        return bus.mem_indirect ? 2 : 1;
    endfunction

    function automatic bit m_need();
        return bus.mem_valid && bus.mem_dmem_op;
    endfunction

    function automatic bit m_mem_ready();
        return !m_need() || (m_k >= m_needed()) || (bus.dmem_resp && (m_k + 1 >= m_needed()));
    endfunction

    function automatic bit m_adv();
        return rst_n && (bus.imem_resp || m_fetched) && m_mem_ready();
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k        <= 0;
            m_fetched  <= 1'b0;
            m_stalls   <= 0;
            m_adv_last <= 1'b1;
        end else begin
            m_adv_last <= m_adv();
            if (m_adv()) begin
                m_k       <= 0;
                m_fetched <= 1'b0;
            end else begin
                if (m_need() && bus.dmem_resp && (m_k < m_needed())) m_k <= m_k + 1;
                if (bus.imem_resp) m_fetched <= 1'b1;
                if (m_stalls < 65535) m_stalls <= m_stalls + 1;
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Every cycle: compare all outputs with what the model says they must be.
    always @(negedge clk) begin
        bit adv, br, lu, need;
        adv  = m_adv();
        br   = bus.br_taken;
        lu   = bus.load_use;
        need = m_need();
        check("imem_read",    bus.imem_read,    rst_n && !m_fetched);
        check("dmem_req",     bus.dmem_req,     rst_n && need && (m_k < m_needed()));
        check("dmem_phase",   bus.dmem_phase,   rst_n && need && (m_needed() == 2) && (m_k == 1));
        check("load_pc",      bus.load_pc,      adv && (br || !lu));
        check("load_if_id",   bus.load_if_id,   adv && (br || !lu));
        check("load_id_ex",   bus.load_id_ex,   adv);
        check("load_ex_mem",  bus.load_ex_mem,  adv);
        check("load_mem_wb",  bus.load_mem_wb,  adv);
        check("flush_if_id",  bus.flush_if_id,  adv && br);
        check("flush_id_ex",  bus.flush_id_ex,  adv && (lu || br));
        check("flush_ex_mem", bus.flush_ex_mem, adv && br);
        check("stall_count",  bus.stall_count,  16'(m_stalls));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit ir, input bit v, input bit op, input bit ind, input bit dr,
                          input bit lu, input bit br);
        bus.imem_resp    = ir;
        bus.mem_valid    = v;
        bus.mem_dmem_op  = op;
        bus.mem_indirect = ind;
        bus.dmem_resp    = dr;
        bus.load_use     = lu;
        bus.br_taken     = br;
    endtask

    // Caller sets the cycle-0 inputs first; returns at the start of cycle 0.
    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();

        // Fetch every cycle, no data access: advance each cycle.
        set_in(1, 0, 0, 0, 0, 0, 0);
        do_reset();
        @(negedge clk);
        check("lit_first_imem_read", bus.imem_read, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            check("lit_stream_load_pc", bus.load_pc, 1);
            check("lit_stream_stall", bus.stall_count, 0);
        end
        step();

        // LDR, fetch at cycle 0, data response at cycle 3.
        set_in(1, 1, 1, 0, 0, 0, 0);
        do_reset();
        @(negedge clk);
        check("lit_ldr_c0_load_pc", bus.load_pc, 0);
        step(); bus.imem_resp = 1'b0;
        @(negedge clk);
        check("lit_ldr_c1_imem_read", bus.imem_read, 0);
        step();
        step(); bus.dmem_resp = 1'b1;
        @(negedge clk);
        check("lit_ldr_c3_advance", bus.load_mem_wb, 1);
        check("lit_ldr_c3_stall", bus.stall_count, 3);
        step(); set_in(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("lit_ldr_c4_stall", bus.stall_count, 3);
        check("lit_ldr_c4_imem_read", bus.imem_read, 1);
        step();

        // LDI, responses at cycles 1 and 3.
        set_in(1, 1, 1, 1, 0, 0, 0);
        do_reset();
        step(); bus.imem_resp = 1'b0; bus.dmem_resp = 1'b1;
        @(negedge clk);
        check("lit_ldi_c1_phase", bus.dmem_phase, 0);
        step(); bus.dmem_resp = 1'b0;
        @(negedge clk);
        check("lit_ldi_c2_phase", bus.dmem_phase, 1);
        step(); bus.dmem_resp = 1'b1;
        @(negedge clk);
        check("lit_ldi_c3_advance", bus.load_ex_mem, 1);
        step(); bus.dmem_resp = 1'b0;
        @(negedge clk);
        check("lit_ldi_c4_phase", bus.dmem_phase, 0);
        check("lit_ldi_c4_req", bus.dmem_req, 1);
        step();

        // Load-use bubble, then branch overriding load-use.
        set_in(1, 0, 0, 0, 0, 1, 0);
        do_reset();
        @(negedge clk);
        check("lit_lu_load_pc", bus.load_pc, 0);
        check("lit_lu_load_if_id", bus.load_if_id, 0);
        check("lit_lu_flush_id_ex", bus.flush_id_ex, 1);
        check("lit_lu_load_id_ex", bus.load_id_ex, 1);
        step(); bus.br_taken = 1'b1;
        @(negedge clk);
        check("lit_br_load_pc", bus.load_pc, 1);
        check("lit_br_flush_if_id", bus.flush_if_id, 1);
        check("lit_br_flush_id_ex", bus.flush_id_ex, 1);
        check("lit_br_flush_ex_mem", bus.flush_ex_mem, 1);
        step();

        // Reset asserted while the indirect second access is outstanding.
        set_in(1, 1, 1, 1, 0, 0, 0);
        do_reset();
        step(); bus.imem_resp = 1'b0; bus.dmem_resp = 1'b1;
        step(); bus.dmem_resp = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("lit_rst_imem_read", bus.imem_read, 0);
        check("lit_rst_dmem_req", bus.dmem_req, 0);
        check("lit_rst_phase", bus.dmem_phase, 0);
        check("lit_rst_load_id_ex", bus.load_id_ex, 0);
        check("lit_rst_stall", bus.stall_count, 0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("lit_rel_phase", bus.dmem_phase, 0);
        check("lit_rel_stall", bus.stall_count, 0);
        check("lit_rel_imem_read", bus.imem_read, 1);
        step();

        // Long stall saturates the counter.
        set_in(0, 0, 0, 0, 0, 0, 0);
        do_reset();
        repeat (70000) step();
        @(negedge clk);
        check("lit_sat_stall", bus.stall_count, 16'hFFFF);
        step();
        @(negedge clk);
        check("lit_sat_hold", bus.stall_count, 16'hFFFF);
        step();

        // Randomized traffic; instruction fields held until the model sees an advance.
        set_in(0, 0, 0, 0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (m_adv_last) begin
                bus.mem_valid    = ($urandom_range(0, 3) != 0);
                bus.mem_dmem_op  = ($urandom_range(0, 1) == 1);
                bus.mem_indirect = ($urandom_range(0, 1) == 1);
            end
            bus.imem_resp = !m_fetched && ($urandom_range(0, 2) == 0);
            bus.dmem_resp = m_need() && (m_k < m_needed()) && ($urandom_range(0, 1) == 1);
            bus.load_use  = ($urandom_range(0, 3) == 0);
            bus.br_taken  = ($urandom_range(0, 4) == 0);
            step();
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
